// File: rtl/calc_pkg.sv
// Shared definitions for the binary calculator datapath: default operand
// geometry and the address-width helper used by the bank, ALU and display.
package calc_pkg;

    // Default operand width and number of operand registers.
    localparam int CALC_WIDTH = 4;
    localparam int CALC_DEPTH = 2;

    // Address width needed to index 'depth' entries; never narrower than one
    // bit so that a port of this width is always legal.
    function automatic int calc_addr_w(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Generalised one-hot write decoder: raises exactly one of N strobes for an
// in-range address when enabled, and nothing otherwise. Addresses that the
// port width can express but that lie at or above N decode to all-zero.
module onehot_decoder
    import calc_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = calc_addr_w(N)
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  sel
);

    logic [N-1:0] sel_s;

    // Compare the address against every legal index; out-of-range never matches.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (addr == AW'(i))) begin
                sel_s[i] = 1'b1;
            end else begin
                sel_s[i] = 1'b0;
            end
        end
    end

    assign sel = sel_s;

endmodule

// File: rtl/operand_bank.sv
// Operand register bank for the calculator. Each rising edge of the debounced
// load button captures data_in into one register, either the one named by
// write_addr or the one under the auto-fill pointer. Tracks which registers
// hold a value and offers two combinational read ports.
module operand_bank
    import calc_pkg::*;
#(
    parameter  int WIDTH  = CALC_WIDTH,
    parameter  int DEPTH  = CALC_DEPTH,
    parameter  int WRAP   = 0,
    localparam int ADDR_W = calc_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              auto_mode,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clear,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic [DEPTH-1:0]  sel,
    output logic [DEPTH-1:0]  valid,
    output logic              full,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              addr_err
);

    // Stored state.
    logic              load_q_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [DEPTH-1:0]  valid_r;
    logic [WIDTH-1:0]  regs_r [DEPTH];

    // Write-path decisions for the current cycle.
    logic              load_rise_s;
    logic [ADDR_W-1:0] target_s;
    logic              in_range_s;
    logic              full_s;
    logic              blocked_s;
    logic              request_s;
    logic              accept_s;
    logic              reject_s;
    logic [DEPTH-1:0]  sel_s;
    logic [ADDR_W-1:0] ptr_next_s;

    // Read-port results.
    logic [WIDTH-1:0]  rd_a_s;
    logic [WIDTH-1:0]  rd_b_s;

    // A write request is a fresh press that is not swallowed by reset or clear.
    always_comb begin
        load_rise_s = load & ~load_q_r;
        full_s      = &valid_r;
        if (auto_mode) begin
            target_s = wr_ptr_r;
        end else begin
            target_s = write_addr;
        end
        request_s = load_rise_s & ~clear & ~rst;
    end

    // The auto pointer is always in range; only addressed writes can miss.
    always_comb begin
        in_range_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (target_s == ADDR_W'(i)) begin
                in_range_s = 1'b1;
            end else begin
                in_range_s = in_range_s;
            end
        end
    end

    // Accept or reject the request; a full bank without wrap refuses auto fills.
    always_comb begin
        if (WRAP == 0) begin
            blocked_s = auto_mode & full_s;
        end else begin
            blocked_s = 1'b0;
        end
        accept_s = request_s & in_range_s & ~blocked_s;
        reject_s = request_s & (~in_range_s | blocked_s);
    end

    // Pointer successor, wrapping at the last implemented register.
    always_comb begin
        if (wr_ptr_r == ADDR_W'(DEPTH - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = wr_ptr_r + ADDR_W'(1);
        end
    end

    onehot_decoder #(
        .N  (DEPTH),
        .AW (ADDR_W)
    ) u_sel_dec (
        .en   (accept_s),
        .addr (target_s),
        .sel  (sel_s)
    );

    // Edge history, pointer, valid flags and register array.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_q_r <= 1'b1;
            wr_ptr_r <= '0;
            valid_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            load_q_r <= load;
            if (clear) begin
                wr_ptr_r <= '0;
                valid_r  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    regs_r[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (sel_s[i]) begin
                        regs_r[i] <= data_in;
                    end else begin
                        regs_r[i] <= regs_r[i];
                    end
                end
                valid_r <= valid_r | sel_s;
                if (accept_s && auto_mode) begin
                    wr_ptr_r <= ptr_next_s;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
            end
        end
    end

    // Read port A: unimplemented addresses read as zero.
    always_comb begin
        rd_a_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                rd_a_s = regs_r[i];
            end else begin
                rd_a_s = rd_a_s;
            end
        end
    end

    // Read port B: unimplemented addresses read as zero.
    always_comb begin
        rd_b_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_b == ADDR_W'(i)) begin
                rd_b_s = regs_r[i];
            end else begin
                rd_b_s = rd_b_s;
            end
        end
    end

    assign rd_data_a = rd_a_s;
    assign rd_data_b = rd_b_s;
    assign sel       = sel_s;
    assign valid     = valid_r;
    assign full      = full_s;
    assign wr_ptr    = wr_ptr_r;
    assign addr_err  = reject_s;

endmodule

// File: tb/tb_operand_bank.sv
// Bench for operand_bank: three instances (DEPTH 2, DEPTH 3 without wrap,
// DEPTH 3 with wrap) share one stimulus stream and are each compared every
// cycle against an array-based model of the bank's behaviour.
module tb_operand_bank;

    logic       clk = 1'b0;
    logic       rst, load, auto_mode, clear;
    logic [3:0] din;
    logic       wa2, ra2, rb2;
    logic [1:0] wa3, ra3, rb3;

    logic [3:0] rda0, rdb0, rda1, rdb1, rda2, rdb2;
    logic [1:0] sel0, vld0;
    logic [2:0] sel1, vld1, sel2, vld2;
    logic       full0, full1, full2, err0, err1, err2;
    logic       ptr0;
    logic [1:0] ptr1, ptr2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_bank #(.WIDTH(4), .DEPTH(2), .WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .load(load), .auto_mode(auto_mode), .write_addr(wa2),
        .data_in(din), .clear(clear), .rd_addr_a(ra2), .rd_addr_b(rb2),
        .rd_data_a(rda0), .rd_data_b(rdb0), .sel(sel0), .valid(vld0), .full(full0),
        .wr_ptr(ptr0), .addr_err(err0));

    operand_bank #(.WIDTH(4), .DEPTH(3), .WRAP(0)) dut1 (
        .clk(clk), .rst(rst), .load(load), .auto_mode(auto_mode), .write_addr(wa3),
        .data_in(din), .clear(clear), .rd_addr_a(ra3), .rd_addr_b(rb3),
        .rd_data_a(rda1), .rd_data_b(rdb1), .sel(sel1), .valid(vld1), .full(full1),
        .wr_ptr(ptr1), .addr_err(err1));

    operand_bank #(.WIDTH(4), .DEPTH(3), .WRAP(1)) dut2 (
        .clk(clk), .rst(rst), .load(load), .auto_mode(auto_mode), .write_addr(wa3),
        .data_in(din), .clear(clear), .rd_addr_a(ra3), .rd_addr_b(rb3),
        .rd_data_a(rda2), .rd_data_b(rdb2), .sel(sel2), .valid(vld2), .full(full2),
        .wr_ptr(ptr2), .addr_err(err2));

    // Reference model state, one row per instance.
    int depth_c [3] = '{2, 3, 3};
    int wrap_c  [3] = '{0, 0, 1};
    int mem     [3][4];
    bit vld     [3][4];
    int ptr     [3];
    bit prevl   [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are already applied (just after a negedge). Compare every output
    // with the model, advance the model across the coming posedge, and return
    // at the next negedge.
    task automatic tick();
        int e_sel [3], e_err [3], e_rda [3], e_rdb [3], e_vld [3], e_full [3], e_ptr [3];
        int tgt [3];
        bit wr [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            int  d  = depth_c[k];
            int  ra = (k == 0) ? int'(ra2) : int'(ra3);
            int  rb = (k == 0) ? int'(rb2) : int'(rb3);
            bit  f  = 1'b1;
            bit  rise;
            tgt[k] = auto_mode ? ptr[k] : ((k == 0) ? int'(wa2) : int'(wa3));
            e_vld[k] = 0;
            for (int i = 0; i < d; i++) begin
                f = f & vld[k][i];
                if (vld[k][i]) e_vld[k] += (1 << i);
            end
            e_full[k] = f;
            e_ptr[k]  = ptr[k];
            e_rda[k]  = (ra < d) ? mem[k][ra] : 0;
            e_rdb[k]  = (rb < d) ? mem[k][rb] : 0;
            rise      = load && !prevl[k];
            e_sel[k]  = 0;
            e_err[k]  = 0;
            wr[k]     = 1'b0;
            if (!rst && !clear && rise) begin
                if (!auto_mode && tgt[k] >= d) e_err[k] = 1;
                else if (auto_mode && f && wrap_c[k] == 0) e_err[k] = 1;
                else begin
                    e_sel[k] = 1 << tgt[k];
                    wr[k] = 1'b1;
                end
            end
        end
        check("sel0", 32'(sel0), e_sel[0]);   check("sel1", 32'(sel1), e_sel[1]);   check("sel2", 32'(sel2), e_sel[2]);
        check("err0", 32'(err0), e_err[0]);   check("err1", 32'(err1), e_err[1]);   check("err2", 32'(err2), e_err[2]);
        check("rda0", 32'(rda0), e_rda[0]);   check("rda1", 32'(rda1), e_rda[1]);   check("rda2", 32'(rda2), e_rda[2]);
        check("rdb0", 32'(rdb0), e_rdb[0]);   check("rdb1", 32'(rdb1), e_rdb[1]);   check("rdb2", 32'(rdb2), e_rdb[2]);
        check("vld0", 32'(vld0), e_vld[0]);   check("vld1", 32'(vld1), e_vld[1]);   check("vld2", 32'(vld2), e_vld[2]);
        check("full0", 32'(full0), e_full[0]); check("full1", 32'(full1), e_full[1]); check("full2", 32'(full2), e_full[2]);
        check("ptr0", 32'(ptr0), e_ptr[0]);   check("ptr1", 32'(ptr1), e_ptr[1]);   check("ptr2", 32'(ptr2), e_ptr[2]);
        for (int k = 0; k < 3; k++) begin
            if (rst || clear) begin
                for (int i = 0; i < 4; i++) begin
                    mem[k][i] = 0;
                    vld[k][i] = 1'b0;
                end
                ptr[k] = 0;
            end else if (wr[k]) begin
                mem[k][tgt[k]] = int'(din);
                vld[k][tgt[k]] = 1'b1;
                if (auto_mode) ptr[k] = (ptr[k] + 1) % depth_c[k];
            end
            prevl[k] = rst ? 1'b1 : load;
        end
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        din  = d;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load = 1'b0;
        clear = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; auto_mode = 1'b0; clear = 1'b0; din = 4'h0;
        wa2 = 1'b0; wa3 = 2'd0; ra2 = 1'b0; rb2 = 1'b1; ra3 = 2'd0; rb3 = 2'd1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                mem[k][i] = 0;
                vld[k][i] = 1'b0;
            end
            ptr[k] = 0;
            prevl[k] = 1'b1;
        end
        @(negedge clk);

        // Button held through reset and afterwards: nothing may be written.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("held_no_valid", 32'(vld0), 32'h0);

        // Addressed writes into the default bank.
        load = 1'b0;
        tick();
        wa2 = 1'b0; wa3 = 2'd0;
        din = 4'h3; load = 1'b1;
        #1 check("addr_sel_first", 32'(sel0), 32'h1);
        tick();
        load = 1'b0; tick();
        wa2 = 1'b1; wa3 = 2'd1;
        din = 4'hA; load = 1'b1;
        #1 check("addr_sel_second", 32'(sel0), 32'h2);
        tick();
        load = 1'b0; ra2 = 1'b0; rb2 = 1'b1;
        tick();
        check("addr_rd_a", 32'(rda0), 32'h3);
        check("addr_rd_b", 32'(rdb0), 32'hA);
        check("addr_full", 32'(full0), 32'h1);

        // Auto fill of a three-deep bank, with and without wrap.
        do_reset();
        auto_mode = 1'b1;
        press(4'h1); press(4'h2); press(4'h3);
        din = 4'h4; load = 1'b1;
        #1 check("auto_full_err", 32'(err1), 32'h1);
        tick();
        load = 1'b0; ra3 = 2'd0; rb3 = 2'd2;
        tick();
        check("auto_nowrap_ptr", 32'(ptr1), 32'h0);
        check("auto_nowrap_reg0", 32'(rda1), 32'h1);
        check("auto_nowrap_reg2", 32'(rdb1), 32'h3);
        check("auto_wrap_ptr", 32'(ptr2), 32'h1);
        check("auto_wrap_reg0", 32'(rda2), 32'h4);

        // Addressed write beyond the bank and a read of the missing register.
        auto_mode = 1'b0; wa3 = 2'd3; wa2 = 1'b0;
        press(4'h5);
        ra3 = 2'd3;
        tick();
        check("oob_valid", 32'(vld1), 32'h7);
        check("oob_read", 32'(rda1), 32'h0);

        // Clear colliding with a fresh press after two auto writes.
        do_reset();
        auto_mode = 1'b1;
        press(4'h7); press(4'h8);
        clear = 1'b1; load = 1'b1;
        tick();
        clear = 1'b0; load = 1'b0;
        tick();
        check("clear_valid", 32'(vld1), 32'h0);
        check("clear_ptr", 32'(ptr1), 32'h0);

        // Long hold in auto mode is one write.
        do_reset();
        auto_mode = 1'b1; din = 4'h9; load = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        load = 1'b0;
        tick();
        check("hold_ptr", 32'(ptr1), 32'h1);
        check("hold_valid", 32'(vld1), 32'h1);

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 99) < 2);
            clear     = ($urandom_range(0, 99) < 6);
            load      = ($urandom_range(0, 1) == 1);
            auto_mode = ($urandom_range(0, 3) != 0);
            din       = 4'($urandom);
            wa2       = 1'($urandom);
            wa3       = 2'($urandom);
            ra2       = 1'($urandom);
            rb2       = 1'($urandom);
            ra3       = 2'($urandom);
            rb3       = 2'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_bank.md
# operand_bank

Parametrised operand register bank for the binary calculator. It generalises the two-operand A/B load decoder to DEPTH registers of WIDTH bits. It adds load-edge detection, an auto-increment fill mode with full/wrap handling, per-register valid flags and two read ports. It sits between the switch/button input stage and the ALU: each press of `load` captures `data_in` into exactly one register.

## Interface
- `WIDTH`, 4, operand width in bits (≥1).
- `DEPTH`, 2, number of operand registers (≥2; need not be a power of two).
- `WRAP`, 0, auto mode behaviour when full: 0 = further loads ignored, 1 = pointer wraps to 0 and overwrites.
- `ADDR_W` is a localparam, not a parameter: `$clog2(DEPTH)`.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `load`  input  1  level from the debounced button; a rising edge requests one write.
- `auto_mode`  input  1  1 = write target is the internal pointer; 0 = write target is `write_addr`.
- `write_addr`  input  ADDR_W  target register in addressed mode.
- `data_in`  input  WIDTH  value to capture.
- `clear`  input  1  synchronous clear of the bank.
- `rd_addr_a`, `rd_addr_b`  input  ADDR_W  read port addresses.
- `rd_data_a`, `rd_data_b`  output  WIDTH  combinational read data.
- `sel`  output  DEPTH  one-hot write strobe; all-zero when no write.
- `valid`  output  DEPTH  bit i = register i has been written since the last reset/clear.
- `full`  output  1  &valid.
- `wr_ptr`  output  ADDR_W  next auto-mode target.
- `addr_err`  output  1  one-cycle pulse when a write is rejected.

## Operation
- Edge detect: `load_q` samples `load` every cycle. `load_rise = load & ~load_q`. Holding `load` produces exactly one write.
- Target selection:
  - Auto mode: target = `wr_ptr`.
  - Addressed mode: target = `write_addr`.
- Accepted write: requires `load_rise`, `~clear`, target < DEPTH, and not (auto mode & `full` & WRAP=0). When accepted:
  - `sel` = one-hot(target).
  - `reg[target]` ← `data_in`.
  - `valid[target]` ← 1.
- Rejected write, `addr_err` = 1 for that cycle and no state changes, in two cases:
  - Addressed target ≥ DEPTH.
  - Auto mode with `full` and WRAP=0.
- Pointer:
  - Advances only on an accepted auto-mode write: `wr_ptr` ← (`wr_ptr` == DEPTH-1) ? 0 : `wr_ptr`+1.
  - With WRAP=0, it stops advancing once full. This is enforced by the rejection rule.
  - Addressed-mode writes never move `wr_ptr`.
- Clear: registers, `valid` and `wr_ptr` ← 0. `load_q` still updates.
- Clear and `load_rise` in the same cycle: clear wins and the edge is consumed. No write and no `addr_err`.
- Reads are combinational from the register array. An address ≥ DEPTH returns 0.
- Switching `auto_mode` never alters `wr_ptr` or `valid`.

## Timing
- Reset values:
  - All registers, `valid`, `wr_ptr`, `sel`, `addr_err` and `full` = 0.
  - `load_q` = 1, so a button held through reset release does not write.
- Write latency:
  - `sel` and `addr_err` are asserted combinationally in the `load_rise` cycle. `sel` is qualified by `~rst`.
  - The register, `valid` and `wr_ptr` update at that cycle's rising edge.
  - `rd_data` reflects the new value in the following cycle.
- Read-during-write to the same address returns the old value in the write cycle.
- `rst` overrides `clear` and `load`.
- Reset mid-fill returns `wr_ptr` to 0 and drops all `valid` bits.
- `load` falling edges have no effect. Re-arming requires `load` low for at least one sampled cycle.

## Structure
- Shared package/header `calc_pkg` holds:
  - Default `CALC_WIDTH` = 4 and `CALC_DEPTH` = 2.
  - A constant function for the `clog2` address width, reused by the ALU and display blocks.
- Sub-module `onehot_decoder` #(N) with ports `en`, `addr` and one-hot `sel`. It is the generalised decoder: all-zero when `en`=0 or `addr` ≥ N. It produces `sel` and the register write enables.
- Top level contains: `load_q`, the pointer, the valid/data arrays and two read multiplexers.

## Test plan
- Reset with `load` held high, then keep `load` high for 5 cycles → no write, `valid`=0, `sel`=0 throughout.
- Defaults, addressed mode: write 4'h3 to addr 0, then 4'hA to addr 1 → `sel`=01 then 10; `rd_data_a`=3, `rd_data_b`=A; `full`=1.
- DEPTH=3, auto mode: load 1, 2, 3, 4 with WRAP=0 → regs {1,2,3}, `wr_ptr` stays 0, 4th load gives `addr_err` pulse. With WRAP=1 the same sequence gives reg0=4 and `wr_ptr`=1.
- DEPTH=3, addressed write to addr 3 → `addr_err`=1 for one cycle, no register or `valid` change; reading addr 3 returns 0.
- `clear` asserted in the same cycle as a `load` rising edge after two auto writes → `valid`=0, `wr_ptr`=0, regs 0, no `sel` and no `addr_err`.
- `load` held high for 10 cycles in auto mode → exactly one write, `wr_ptr` advances by 1.
